pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 15 +
 rtl/pc_sequencer.sv | 131 +++++++++++++
 tb/tb_pc_sequencer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_seq_pkg;

    // Sequencer mode: normal fetch or executing the interrupt handler.
    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam int unsigned DEF_INC       = 4;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: sequential step, branch/jump redirect, single-level interrupt trap and mret.
// Latency: redirect/trap/mret visible on pc one cycle after the update cycle.
// Backpressure: stall=1 or fetch_ready=0 freezes pc/epc/state; only the irq pending latch may still set.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall, fetch_ready       an update cycle needs stall=0 and fetch_ready=1
//   pc_valid, pc             fetch request and its address (registered)
//   br_en, br_taken, jmp_en  redirect requests, target is the redirect address
//   irq, isr_addr            level interrupt and handler entry address
//   mret, epc, in_isr        handler return, saved return address, handler-active flag
//   misalign_err             one-cycle pulse on a misaligned taken redirect
//
// Optional feature: define PC_SEQ_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter int unsigned     INC       = DEF_INC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            pc_valid,
    output logic [XLEN-1:0] pc,
    input  logic            br_en,
    input  logic            br_taken,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] target,
    input  logic            irq,
    input  logic [XLEN-1:0] isr_addr,
    input  logic            mret,
    output logic [XLEN-1:0] epc,
    output logic            in_isr,
    output logic            misalign_err
);

    state_t          r_state,   w_state_nxt;
    logic [XLEN-1:0] r_pc,      w_pc_nxt;
    logic [XLEN-1:0] r_epc,     w_epc_nxt;
    logic            r_pend,    w_pend_nxt;
    logic            r_mis,     w_mis_nxt;
    logic [1:0]      r_vcnt;

    logic            w_update;
    logic            w_redir;
    logic            w_misal;
    logic            w_trap;
    logic [XLEN-1:0] w_pc_inc;

    assign w_update = ~stall & fetch_ready;
    assign w_redir  = jmp_en | (br_en & br_taken);
    // Plain XLEN-bit add: carry out is dropped, so the step wraps at 2^XLEN.
    assign w_pc_inc = r_pc + XLEN'(INC);
    assign w_trap   = (r_state == ST_RUN) && (r_pend || irq);

`ifdef PC_SEQ_MISALIGN_CHECK_EN
    // INC is a power of two, so INC-1 masks exactly the low log2(INC) bits.
    assign w_misal = w_redir && ((target & XLEN'(INC - 1)) != '0);
`else
    assign w_misal = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_pend_nxt  = r_pend;
        w_mis_nxt   = 1'b0;

        if (w_update) begin
            if (w_trap) begin
                // Return lands where this cycle's instruction would have gone.
                w_epc_nxt   = w_redir ? target : w_pc_inc;
                w_pc_nxt    = isr_addr;
                w_state_nxt = ST_ISR;
                w_pend_nxt  = 1'b0;
            end else if ((r_state == ST_ISR) && mret) begin
                w_pc_nxt    = r_epc;
                w_state_nxt = ST_RUN;
            end else if (w_misal) begin
                w_mis_nxt = 1'b1;
                if (r_state == ST_RUN) begin
                    w_epc_nxt   = r_pc;
                    w_pc_nxt    = isr_addr;
                    w_state_nxt = ST_ISR;
                end else begin
                    // No nesting: inside the handler the bad redirect is dropped.
                    w_pc_nxt = w_pc_inc;
                end
            end else if (w_redir) begin
                w_pc_nxt = target;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end else if ((r_state == ST_RUN) && irq) begin
            // Remember an interrupt that arrives while fetch is held off.
            w_pend_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_pend  <= 1'b0;
            r_mis   <= 1'b0;
            r_vcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_pend  <= w_pend_nxt;
            r_mis   <= w_mis_nxt;
            // Counts the two post-reset cycles during which pc is not yet valid.
            if (r_vcnt != 2'd2) begin
                r_vcnt <= r_vcnt + 2'd1;
            end
        end
    end

    assign pc           = r_pc;
    assign epc          = r_epc;
    assign in_isr       = (r_state == ST_ISR);
    assign pc_valid     = (r_vcnt == 2'd2);
    assign misalign_err = r_mis;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam int unsigned INC   = 4;
    localparam longint unsigned MOD = 64'h1_0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        fetch_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic        br_en;
    logic        br_taken;
    logic        jmp_en;
    logic [31:0] target;
    logic        irq;
    logic [31:0] isr_addr;
    logic        mret;
    logic [31:0] epc;
    logic        in_isr;
    logic        misalign_err;

    pc_sequencer #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .INC       (INC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .fetch_ready  (fetch_ready),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .br_en        (br_en),
        .br_taken     (br_taken),
        .jmp_en       (jmp_en),
        .target       (target),
        .irq          (irq),
        .isr_addr     (isr_addr),
        .mret         (mret),
        .epc          (epc),
        .in_isr       (in_isr),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference model: architectural state kept as plain integers.
    longint unsigned m_pc, m_epc;
    bit              m_isr, m_pend, m_mis;
    int              m_since_rst;

    task automatic model_step();
        bit upd, redir, bad;
        upd   = !stall && fetch_ready;
        redir = jmp_en || (br_en && br_taken);
`ifdef PC_SEQ_MISALIGN_CHECK_EN
        bad   = redir && ((longint'(target) % INC) != 0);
`else
        bad   = 1'b0;
`endif
        if (rst) begin
            m_pc = 0; m_epc = 0; m_isr = 0; m_pend = 0; m_mis = 0; m_since_rst = 0;
        end else begin
            if (m_since_rst < 2) m_since_rst++;
            m_mis = 0;
            if (!upd) begin
                if (!m_isr && irq) m_pend = 1;
            end else if (!m_isr && (m_pend || irq)) begin
                m_epc  = redir ? longint'(target) : (m_pc + INC) % MOD;
                m_pc   = isr_addr;
                m_isr  = 1;
                m_pend = 0;
            end else if (m_isr && mret) begin
                m_pc  = m_epc;
                m_isr = 0;
            end else if (bad) begin
                m_mis = 1;
                if (!m_isr) begin
                    m_epc = m_pc;
                    m_pc  = isr_addr;
                    m_isr = 1;
                end else begin
                    m_pc = (m_pc + INC) % MOD;
                end
            end else if (redir) begin
                m_pc = target;
            end else begin
                m_pc = (m_pc + INC) % MOD;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; fetch_ready = 1; br_en = 0; br_taken = 0; jmp_en = 0;
        target = 32'h0; irq = 0; mret = 0; isr_addr = 32'h800;
    endtask

    typedef struct {
        logic        rst, stall, fr, br_en, br_taken, jmp_en;
        logic [31:0] target;
        logic        irq, mret;
        logic [31:0] e_pc, e_epc;
        logic        e_isr, e_valid;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic f, input logic be, input logic bt,
                       input logic j, input logic [31:0] t, input logic q, input logic m,
                       input logic [31:0] p, input logic [31:0] e, input logic i, input logic v);
        vec_t x;
        x.rst = r; x.stall = s; x.fr = f; x.br_en = be; x.br_taken = bt; x.jmp_en = j;
        x.target = t; x.irq = q; x.mret = m; x.e_pc = p; x.e_epc = e; x.e_isr = i; x.e_valid = v;
        tbl.push_back(x);
    endtask

    initial begin
        idle_inputs();
        // rst st fr be bt jm target        irq mret  pc             epc     isr valid
        add(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,   0, 0);
        add(1, 1, 1, 1, 1, 1, 32'h100,      1, 1, 32'h0,        32'h0,   0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,   0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h8,        32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'hC,        32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h10,       32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 1, 32'h20,       0, 0, 32'h20,       32'h0,   0, 1);
        add(0, 0, 1, 0, 1, 0, 32'h100,      0, 0, 32'h24,       32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 1, 32'h20,       0, 0, 32'h20,       32'h0,   0, 1);
        add(0, 0, 1, 1, 1, 0, 32'h100,      0, 0, 32'h100,      32'h0,   0, 1);
        add(0, 0, 1, 1, 0, 0, 32'h300,      0, 0, 32'h104,      32'h0,   0, 1);
        add(0, 1, 1, 0, 0, 1, 32'h500,      0, 0, 32'h104,      32'h0,   0, 1);
        add(0, 0, 0, 0, 0, 1, 32'h500,      0, 0, 32'h104,      32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 1, 32'h40,       0, 0, 32'h40,       32'h0,   0, 1);
        add(0, 1, 1, 0, 0, 0, 32'h0,        1, 0, 32'h40,       32'h0,   0, 1);
        add(0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 32'h40,       32'h0,   0, 1);
        add(0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 32'h40,       32'h0,   0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h800,      32'h44,  1, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h804,      32'h44,  1, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h808,      32'h44,  1, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        1, 1, 32'h44,       32'h44,  0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h800,      32'h48,  1, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 1, 32'h48,       32'h48,  0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 1, 32'h4C,       32'h48,  0, 1);
        add(0, 0, 1, 0, 0, 1, 32'h200,      1, 0, 32'h800,      32'h200, 1, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 1, 32'h200,      32'h200, 0, 1);
        add(0, 0, 1, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 32'h200, 0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h200, 0, 1);
        add(0, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h800,      32'h4,   1, 1);
        add(1, 0, 1, 0, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,   0, 0);
        add(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,   0, 0);
        add(0, 0, 1, 0, 0, 0, 32'h0,        0, 0, 32'h4,        32'h0,   0, 1);

        for (int k = 0; k < tbl.size(); k++) begin
            rst = tbl[k].rst; stall = tbl[k].stall; fetch_ready = tbl[k].fr;
            br_en = tbl[k].br_en; br_taken = tbl[k].br_taken; jmp_en = tbl[k].jmp_en;
            target = tbl[k].target; irq = tbl[k].irq; mret = tbl[k].mret;
            tick();
            check($sformatf("tbl%0d.pc", k), pc, tbl[k].e_pc);
            check($sformatf("tbl%0d.epc", k), epc, tbl[k].e_epc);
            check($sformatf("tbl%0d.in_isr", k), 32'(in_isr), 32'(tbl[k].e_isr));
            check($sformatf("tbl%0d.pc_valid", k), 32'(pc_valid), 32'(tbl[k].e_valid));
            check($sformatf("tbl%0d.misalign_err", k), 32'(misalign_err), 32'h0);
        end

`ifdef PC_SEQ_MISALIGN_CHECK_EN
        // Misaligned jump in RUN traps; in ISR it is dropped with a pulse.
        idle_inputs(); jmp_en = 1; target = 32'h10; tick();
        check("mis.setup_pc", pc, 32'h10);
        target = 32'h102; tick();
        check("mis.pc", pc, 32'h800);
        check("mis.epc", epc, 32'h10);
        check("mis.in_isr", 32'(in_isr), 32'h1);
        check("mis.pulse", 32'(misalign_err), 32'h1);
        idle_inputs(); tick();
        check("mis.pulse_end", 32'(misalign_err), 32'h0);
        check("mis.step_pc", pc, 32'h804);
        jmp_en = 1; target = 32'h102; tick();
        check("mis.isr_pc", pc, 32'h808);
        check("mis.isr_pulse", 32'(misalign_err), 32'h1);
        idle_inputs(); mret = 1; tick();
        check("mis.mret_pc", pc, 32'h10);
`endif

        // Randomized phase against the reference model.
        idle_inputs(); rst = 1; tick();
        for (int n = 0; n < 1500; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            fetch_ready = ($urandom_range(0, 4) != 0);
            br_en       = ($urandom_range(0, 3) == 0);
            br_taken    = $urandom_range(0, 1);
            jmp_en      = ($urandom_range(0, 7) == 0);
            target      = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 15) == 0) target = 32'hFFFF_FFFC;
            irq         = ($urandom_range(0, 9) == 0);
            mret        = ($urandom_range(0, 5) == 0);
            isr_addr    = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : 32'h800;
            tick();
            check("rnd.pc", pc, 32'(m_pc));
            check("rnd.epc", epc, 32'(m_epc));
            check("rnd.in_isr", 32'(in_isr), 32'(m_isr));
            check("rnd.pc_valid", 32'(pc_valid), 32'(m_since_rst >= 2));
            check("rnd.misalign_err", 32'(misalign_err), 32'(m_mis));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
